// File: rtl/vga_color_encoder_if.sv
// vga_color_encoder_if: truecolor pixel stream in, RGB332 code stream out.
interface vga_color_encoder_if;
  logic [23:0] in_color;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [7:0]  out_code;
  logic        out_eol;
  logic        out_eof;
  logic        out_valid;
  logic        out_ready;
  modport master (
    output in_color, in_valid, in_sof, out_ready,
    input  in_ready, out_code, out_eol, out_eof, out_valid
  );
  modport slave (
    input  in_color, in_valid, in_sof, out_ready,
    output in_ready, out_code, out_eol, out_eof, out_valid
  );
endinterface

// File: rtl/vga_color_encoder.sv
// vga_color_encoder: 2-stage RGB888 -> RGB332 encoder with line/frame tagging.
// Optional 2x2 ordered dither is compiled in when VGA_ENC_DITHER_EN is defined.
module vga_color_encoder #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input logic               clk,
  input logic               reset,
  vga_color_encoder_if.slave bus
);
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int YW = $clog2(FRAME_HEIGHT);
  logic [XW-1:0] x, tx;
  logic [YW-1:0] y, ty;
  logic          s1_valid, s1_eol, s1_eof;
  logic [8:0]    s1_r, s1_g, s1_b;
  logic          adv1, adv2, acc, last_x, last_y;
  logic [7:0]    d_rg, d_b;
  assign adv2         = !bus.out_valid || bus.out_ready;
  assign adv1         = !s1_valid || adv2;
  assign bus.in_ready = adv1 && !reset;
  assign acc          = bus.in_valid && bus.in_ready;
  // start-of-frame forces the tag to (0,0) for this very pixel
  assign tx     = bus.in_sof ? '0 : x;
  assign ty     = bus.in_sof ? '0 : y;
  assign last_x = tx == XW'(LINE_WIDTH - 1);
  assign last_y = ty == YW'(FRAME_HEIGHT - 1);
`ifdef VGA_ENC_DITHER_EN
  assign d_rg = ty[0] ? (tx[0] ? 8'd8 : 8'd24) : (tx[0] ? 8'd16 : 8'd0);
  assign d_b  = {d_rg[6:0], 1'b0};
`else
  assign d_rg = 8'd0;
  assign d_b  = 8'd0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      x             <= '0;
      y             <= '0;
      s1_valid      <= 1'b0;
      s1_eol        <= 1'b0;
      s1_eof        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_code  <= 8'd0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
    end else begin
      if (acc) begin
        x <= last_x ? '0 : tx + 1'b1;
        y <= last_x ? (last_y ? '0 : ty + 1'b1) : ty;
      end
      if (adv1) begin
        s1_valid <= bus.in_valid;
        s1_r     <= {1'b0, bus.in_color[23:16]} + {1'b0, d_rg};
        s1_g     <= {1'b0, bus.in_color[15:8]} + {1'b0, d_rg};
        s1_b     <= {1'b0, bus.in_color[7:0]} + {1'b0, d_b};
        s1_eol   <= last_x;
        s1_eof   <= last_x && last_y;
      end
      if (adv2) begin
        bus.out_valid <= s1_valid;
        bus.out_code  <= {s1_r[8] ? 3'b111 : s1_r[7:5],
                          s1_g[8] ? 3'b111 : s1_g[7:5],
                          s1_b[8] ? 2'b11  : s1_b[7:6]};
        bus.out_eol   <= s1_eol;
        bus.out_eof   <= s1_eof;
      end
    end
  end
endmodule

// File: tb/tb_vga_color_encoder.sv
// tb_vga_color_encoder: randomized and directed checks against a queue-based reference model.
module tb_vga_color_encoder;
  localparam int LW = 4;
  localparam int FH = 2;
  typedef struct {
    logic [9:0] v;
    int         cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  vga_color_encoder_if bus();
  vga_color_encoder #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  exp_t       exp_q[$];
  logic [9:0] obs_q[$];
  int         n_tests = 0, n_fail = 0, cyc = 0, mx = 0, my = 0, n_acc = 0;
  bit         lat_chk = 0, hold_pend = 0;
  logic [9:0] held;
  int         rg_t[4] = '{0, 16, 24, 8};
  int         b_t[4]  = '{0, 32, 48, 16};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic acc_model(input logic [23:0] c, input logic sof);
    logic [31:0] r, g, b;
    int   rg, bo;
    exp_t e;
    if (sof) begin mx = 0; my = 0; end
    rg = 0; bo = 0;
`ifdef VGA_ENC_DITHER_EN
    rg = rg_t[mx % 2 + 2 * (my % 2)];
    bo = b_t[mx % 2 + 2 * (my % 2)];
`endif
    r = c[23:16] + rg; if (r > 255) r = 255;
    g = c[15:8] + rg;  if (g > 255) g = 255;
    b = c[7:0] + bo;   if (b > 255) b = 255;
    e.v   = {mx == LW - 1, mx == LW - 1 && my == FH - 1, r[7:5], g[7:5], b[7:6]};
    e.cyc = cyc;
    exp_q.push_back(e);
    mx++;
    if (mx == LW) begin mx = 0; my = (my + 1) % FH; end
  endtask

  task automatic cycle(input logic v, input logic [23:0] c, input logic sof, input logic ordy);
    logic [9:0] cur;
    exp_t e;
    @(negedge clk);
    bus.in_valid = v; bus.in_color = c; bus.in_sof = sof; bus.out_ready = ordy;
    #1;
    cyc++;
    cur = {bus.out_eol, bus.out_eof, bus.out_code};
    if (hold_pend) check("hold", {21'd0, bus.out_valid, cur}, {21'd0, 1'b1, held});
    hold_pend = bus.out_valid && !bus.out_ready && !reset;
    held = cur;
    if (bus.out_valid && bus.out_ready) begin
      obs_q.push_back(cur);
      if (exp_q.size() == 0) check("extra_out", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("pix", {22'd0, cur}, {22'd0, e.v});
        if (lat_chk) check("latency", cyc - e.cyc, 2);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      n_acc++;
      acc_model(c, sof);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle(0, 24'd0, 0, 0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 0);
      if (i > 0) check("rst_out", {21'd0, bus.out_valid, bus.out_eol, bus.out_eof, bus.out_code}, 0);
    end
    exp_q.delete();
    mx = 0; my = 0; hold_pend = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, bus.in_ready}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(0, 24'd0, 0, 1);
    check("drain", 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [23:0] cs[3];
    logic [7:0]  ii;
    bus.in_valid = 0; bus.in_color = 0; bus.in_sof = 0; bus.out_ready = 0;
    do_reset(3);
    // palette sweep with latency check
    obs_q.delete();
    lat_chk = 1;
    for (int i = 0; i < 256; i++) begin
      ii = 8'(i);
      cycle(1, {ii[7:5], ii[7:5], ii[7:6], ii[4:2], ii[4:2], ii[4:3],
                ii[1:0], ii[1:0], ii[1:0], ii[1:0]}, i == 0, 1);
    end
    drain();
    lat_chk = 0;
    check("sweep_count", 32'(obs_q.size()), 256);
`ifndef VGA_ENC_DITHER_EN
    for (int i = 0; i < 256 && i < obs_q.size(); i++) check("roundtrip", {24'd0, obs_q[i][7:0]}, i);
`else
    do_reset(2);
    obs_q.delete();
    for (int i = 0; i < 6; i++) cycle(1, 24'h101020, i == 0, 1);
    drain();
    check("dith00", {24'd0, obs_q[0][7:0]}, 32'h00);
    check("dith10", {24'd0, obs_q[1][7:0]}, 32'h25);
    check("dith01", {24'd0, obs_q[4][7:0]}, 32'h25);
    check("dith11", {24'd0, obs_q[5][7:0]}, 32'h00);
    do_reset(2);
    obs_q.delete();
    for (int i = 0; i < 5; i++) cycle(1, i == 4 ? 24'hFFFFFF : 24'h0, 0, 1);
    drain();
    check("dith_sat", {24'd0, obs_q[4][7:0]}, 32'hFF);
`endif
    // backpressure: two pixels buffer, third waits
    do_reset(2);
    obs_q.delete();
    for (int i = 0; i < 3; i++) cs[i] = 24'($urandom);
    n_acc = 0;
    for (int i = 0; i < 5; i++) cycle(n_acc < 3, cs[n_acc < 3 ? n_acc : 0], 0, 0);
    check("bp_accepts", n_acc, 2);
    check("bp_in_ready", {31'd0, bus.in_ready}, 0);
    for (int i = 0; i < 20 && n_acc < 3; i++) cycle(1, cs[n_acc], 0, 1);
    drain();
    check("bp_count", 32'(obs_q.size()), 3);
    // line/frame flags
    do_reset(2);
    obs_q.delete();
    for (int i = 0; i < 8; i++) cycle(1, 24'($urandom), 0, 1);
    drain();
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      check("eol8", {31'd0, obs_q[i][9]}, {31'd0, i == 3 || i == 7});
      check("eof8", {31'd0, obs_q[i][8]}, {31'd0, i == 7});
    end
    do_reset(2);
    obs_q.delete();
    for (int i = 0; i < 6; i++) cycle(1, 24'($urandom), i == 2, 1);
    drain();
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check("eol_sof", {31'd0, obs_q[i][9]}, {31'd0, i == 5});
    // reset with pixels in flight
    do_reset(2);
    obs_q.delete();
    for (int i = 0; i < 2; i++) cycle(1, 24'($urandom), 0, 0);
    do_reset(2);
    for (int i = 0; i < 4; i++) cycle(1, 24'($urandom), 0, 1);
    drain();
    check("rst_flight_count", 32'(obs_q.size()), 4);
    if (obs_q.size() == 4) begin
      check("rst_flight_eol0", {31'd0, obs_q[2][9]}, 0);
      check("rst_flight_eol", {31'd0, obs_q[3][9]}, 1);
    end
    // random traffic
    do_reset(2);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 7);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
